// File: rtl/dwt_subband_buffer.sv
// dwt_subband_buffer: stores one frame of L/H coefficient pairs and re-emits it in subband order
module dwt_subband_buffer #(
    parameter int W     = 8,
    parameter int FRAME = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_low,
    input  logic [W-1:0] in_high,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_band,
    output logic         out_last,
    output logic [7:0]   frame_cnt
);
    localparam int AW = $clog2(FRAME);
    localparam logic [AW-1:0] LAST = AW'(FRAME - 1);

    typedef enum logic [1:0] {FILL, DRAIN_L, DRAIN_H} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem_l [FRAME];
    logic [W-1:0]  mem_h [FRAME];
    logic          wr_en, rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    // Outputs decode only from registered state, so in_* never reaches out_* combinationally
    always_comb begin
        state_nxt = state;
        in_ready  = state == FILL;
        out_valid = state != FILL;
        out_band  = state == DRAIN_H;
        out_last  = state == DRAIN_H && rd_ptr == LAST;
        out_data  = state == DRAIN_L ? mem_l[rd_ptr] : state == DRAIN_H ? mem_h[rd_ptr] : '0;
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
        if (wr_en && wr_ptr == LAST) state_nxt = DRAIN_L;
        if (rd_en && rd_ptr == LAST) state_nxt = state == DRAIN_L ? DRAIN_H : FILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < FRAME; i++) begin
                mem_l[i] <= '0;
                mem_h[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_l[wr_ptr] <= in_low;
                mem_h[wr_ptr] <= in_high;
                wr_ptr        <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
                if (wr_ptr == LAST) rd_ptr <= '0;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
                if (state == DRAIN_H && rd_ptr == LAST) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dwt_subband_buffer.sv
// tb_dwt_subband_buffer: randomized frames checked against a subband-order reference model
module tb_dwt_subband_buffer;
    logic       clk = 0;
    logic       rst = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_low = 0;
    logic [7:0] in_high = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [7:0] out_data;
    logic       out_band;
    logic       out_last;
    logic [7:0] frame_cnt;

    dwt_subband_buffer #(.W(8), .FRAME(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_low(in_low), .in_high(in_high),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_band(out_band), .out_last(out_last), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frames_done = 0;

    logic [7:0] lo [8];
    logic [7:0] hi [8];
    logic [7:0] exp_d [16];
    logic       exp_b [16];
    logic       exp_l [16];
    logic [7:0] obs_d [16];
    logic       obs_b [16];
    logic       obs_l [16];
    int n_acc, n_obs, busy, hold_bad, held3, first_valid, ready_after, saw_aa;
    int fc_before_last, fc_after;

    // Mallat order: every L of the frame, then every H; last flag only on the final H
    function automatic void build_expected();
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = i < 8 ? lo[i] : hi[i-8];
            exp_b[i] = i >= 8;
            exp_l[i] = i == 15;
        end
    endfunction

    function automatic void fixed_frame();
        for (int i = 0; i < 8; i++) begin
            lo[i] = 8'(i + 1);
            hi[i] = 8'(i + 101);
        end
    endfunction

    function automatic void random_frame(input int cap);
        for (int i = 0; i < 8; i++) begin
            lo[i] = 8'($urandom_range(0, cap));
            hi[i] = 8'($urandom_range(0, cap));
        end
    endfunction

    // gap: 0 back-to-back, 1 idle every other cycle, 2 random idles
    task automatic push_frame(input int gap, input int npairs);
        int cyc = 0;
        n_acc = 0;
        while (n_acc < npairs && cyc < 100) begin
            @(negedge clk);
            in_valid = gap == 0 ? 1'b1 : gap == 1 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            in_low   = in_valid ? lo[n_acc] : 8'($urandom);
            in_high  = in_valid ? hi[n_acc] : 8'($urandom);
            if (in_valid && in_ready) n_acc++;
            cyc++;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    // stall: 0 none, 1 random out_ready, 2 three-cycle stall on L word 3
    task automatic collect(input int stall, input logic drain_in);
        int cyc = 0;
        int stall_left = 0;
        logic stall_done = 0;
        logic pv = 0;
        logic [7:0] pd = 0;
        logic pb = 0, pl = 0;
        n_obs = 0; busy = 0; hold_bad = 0; held3 = 0; saw_aa = 0;
        while (n_obs < 16 && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) first_valid = out_valid;
            if (pv && (!out_valid || out_data !== pd || out_band !== pb || out_last !== pl)) hold_bad++;
            if (stall == 2 && !stall_done && out_valid && out_data == 3 && !out_band) begin
                stall_left = 3;
                stall_done = 1;
            end
            out_ready = stall == 1 ? 1'($urandom_range(0, 1)) : stall_left == 0;
            if (stall_left > 0) stall_left--;
            in_valid = drain_in;
            in_low   = 8'hAA;
            in_high  = 8'hAA;
            if (!in_ready) busy++;
            if (!out_ready && out_valid && out_data == 3 && !out_band) held3++;
            if (out_valid && out_ready) begin
                if (n_obs == 15) fc_before_last = frame_cnt;
                if (out_data == 8'hAA) saw_aa++;
                obs_d[n_obs] = out_data;
                obs_b[n_obs] = out_band;
                obs_l[n_obs] = out_last;
                n_obs++;
            end
            pv = out_valid && !out_ready;
            pd = out_data; pb = out_band; pl = out_last;
            cyc++;
        end
        @(negedge clk);
        in_valid    = 0;
        out_ready   = 1;
        ready_after = in_ready;
        fc_after    = frame_cnt;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1;
            in_low = 8'($urandom);
            in_high = 8'($urandom);
            checks++;
            if ({in_ready, out_valid, out_data, out_band, out_last, frame_cnt} !== {1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0}) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%0d band=%0b last=%0b fc=%0d, exp rdy=1 vld=0 data=0 band=0 last=0 fc=0",
                         in_ready, out_valid, out_data, out_band, out_last, frame_cnt);
            end
        end
        in_valid = 0;
        rst = 1;
    endtask

    task automatic test_basic();
        fixed_frame();
        build_expected();
        push_frame(0, 8);
        collect(0, 0);
        checks++;
        if (n_acc !== 8 || n_obs !== 16) begin
            errors++;
            $display("FAIL basic_progress: got acc=%0d out=%0d, exp acc=8 out=16", n_acc, n_obs);
        end
        for (int i = 0; i < n_obs; i++) begin
            checks++;
            if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                errors++;
                $display("FAIL basic_word[%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                         i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
            end
        end
        checks++;
        if (first_valid !== 1 || busy !== 16 || ready_after !== 1) begin
            errors++;
            $display("FAIL basic_timing: got first_valid=%0d busy=%0d ready_after=%0d, exp 1 16 1", first_valid, busy, ready_after);
        end
        checks++;
        if (fc_before_last !== frames_done % 256 || fc_after !== (frames_done + 1) % 256) begin
            errors++;
            $display("FAIL basic_frame_cnt: got %0d->%0d, exp %0d->%0d", fc_before_last, fc_after, frames_done % 256, (frames_done + 1) % 256);
        end
        frames_done++;
    endtask

    task automatic test_gaps();
        for (int g = 1; g <= 2; g++) begin
            if (g == 1) fixed_frame(); else random_frame(255);
            build_expected();
            push_frame(g, 8);
            collect(0, 0);
            frames_done++;
            checks++;
            if (n_acc !== 8 || n_obs !== 16 || first_valid !== 1 || busy !== 16) begin
                errors++;
                $display("FAIL gaps_timing[%0d]: got acc=%0d out=%0d first_valid=%0d busy=%0d, exp 8 16 1 16", g, n_acc, n_obs, first_valid, busy);
            end
            for (int i = 0; i < n_obs; i++) begin
                checks++;
                if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                    errors++;
                    $display("FAIL gaps_word[%0d][%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                             g, i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int s = 2; s >= 1; s--) begin
            if (s == 2) fixed_frame(); else random_frame(255);
            build_expected();
            push_frame(0, 8);
            collect(s, 0);
            frames_done++;
            checks++;
            if (n_obs !== 16 || hold_bad !== 0 || (s == 2 && held3 !== 3)) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got out=%0d hold_bad=%0d held3=%0d, exp out=16 hold_bad=0 held3=3", s, n_obs, hold_bad, held3);
            end
            for (int i = 0; i < n_obs; i++) begin
                checks++;
                if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                    errors++;
                    $display("FAIL backpressure_word[%0d][%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                             s, i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_drain_input();
        random_frame(127);
        push_frame(0, 8);
        collect(0, 1);
        frames_done++;
        checks++;
        if (busy !== 16) begin
            errors++;
            $display("FAIL drain_input_ready: got busy=%0d, exp 16", busy);
        end
        random_frame(127);
        build_expected();
        push_frame(2, 8);
        collect(1, 1);
        frames_done++;
        checks++;
        if (n_obs !== 16 || saw_aa !== 0) begin
            errors++;
            $display("FAIL drain_input_leak: got out=%0d aa_words=%0d, exp out=16 aa_words=0", n_obs, saw_aa);
        end
        for (int i = 0; i < n_obs; i++) begin
            checks++;
            if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                errors++;
                $display("FAIL drain_input_word[%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                         i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int cyc = 0;
        logic found = 0;
        fixed_frame();
        push_frame(0, 8);
        while (!found && cyc < 100) begin
            @(negedge clk);
            out_ready = 1;
            found = out_valid && out_band && out_data == 105;
            cyc++;
        end
        #2 rst = 0;
        #1;
        checks++;
        if (!found || out_valid !== 0 || frame_cnt !== 0 || in_ready !== 1 || out_data !== 0) begin
            errors++;
            $display("FAIL reset_mid_drain: got found=%0b vld=%0b fc=%0d rdy=%0b data=%0d, exp found=1 vld=0 fc=0 rdy=1 data=0",
                     found, out_valid, frame_cnt, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1;
        frames_done = 0;
        for (int i = 0; i < 8; i++) begin
            lo[i] = 8'hEE;
            hi[i] = 8'hEE;
        end
        push_frame(0, 3);
        #2 rst = 0;
        @(negedge clk);
        rst = 1;
        random_frame(200);
        build_expected();
        push_frame(0, 8);
        collect(0, 0);
        checks++;
        if (n_obs !== 16 || fc_after !== 1) begin
            errors++;
            $display("FAIL reset_recover: got out=%0d fc=%0d, exp out=16 fc=1", n_obs, fc_after);
        end
        for (int i = 0; i < n_obs; i++) begin
            checks++;
            if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                errors++;
                $display("FAIL reset_recover_word[%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                         i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
            end
        end
        frames_done++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        frames_done = 0;
        for (int f = 0; f < 257; f++) begin
            random_frame(255);
            build_expected();
            push_frame(0, 8);
            collect(0, 0);
            checks++;
            if (n_obs !== 16 || fc_before_last !== frames_done % 256 || fc_after !== (frames_done + 1) % 256) begin
                errors++;
                $display("FAIL wrap_frame_cnt[%0d]: got out=%0d fc %0d->%0d, exp out=16 fc %0d->%0d",
                         f, n_obs, fc_before_last, fc_after, frames_done % 256, (frames_done + 1) % 256);
            end
            frames_done++;
            if (f == 256) begin
                for (int i = 0; i < n_obs; i++) begin
                    checks++;
                    if ({obs_d[i], obs_b[i], obs_l[i]} !== {exp_d[i], exp_b[i], exp_l[i]}) begin
                        errors++;
                        $display("FAIL wrap_word[%0d]: got data=%0d band=%0b last=%0b, exp data=%0d band=%0b last=%0b",
                                 i, obs_d[i], obs_b[i], obs_l[i], exp_d[i], exp_b[i], exp_l[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_drain_input();
        test_reset_mid_drain();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
